bus_err_arb: RTL and testbench

BUS_ERR_ARB -- requirements
Module: bus_err_arb

---
 rtl/bus_err_arb.sv | 168 ++++++++++++++++
 tb/tb_bus_err_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_err_arb.sv
// rtl/bus_err_arb.sv - round-robin merge of per-source error reports; optional drop counter via BUS_ERR_ARB_DROP_CNT_EN
module bus_err_arb #(
    parameter int NumSrc    = 4,
    parameter int AddrWidth = 48,
    parameter int ErrBits   = 3,
    parameter int CntWidth  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumSrc-1:0]             src_valid_i,
    input  logic [NumSrc*AddrWidth-1:0]   src_addr_i,
    input  logic [NumSrc*ErrBits-1:0]     src_code_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic [ErrBits-1:0]            out_code_o,
    output logic [$clog2(NumSrc)-1:0]     out_src_o,
    output logic [NumSrc-1:0]             drop_o,
    input  logic                          cnt_clr_i,
    output logic [CntWidth-1:0]           drop_cnt_o
);
    localparam int SrcW = $clog2(NumSrc);

    logic [NumSrc-1:0]    slot_vld_q, slot_vld_d;
    logic [AddrWidth-1:0] slot_addr_q [NumSrc];
    logic [AddrWidth-1:0] slot_addr_d [NumSrc];
    logic [ErrBits-1:0]   slot_code_q [NumSrc];
    logic [ErrBits-1:0]   slot_code_d [NumSrc];

    logic                 out_vld_q, out_vld_d;
    logic [AddrWidth-1:0] out_addr_q, out_addr_d;
    logic [ErrBits-1:0]   out_code_q, out_code_d;
    logic [SrcW-1:0]      out_src_q, out_src_d;
    logic [SrcW-1:0]      last_q, last_d;

    logic                 load;
    logic                 gnt_any;
    logic [SrcW-1:0]      gnt_idx;
    logic [SrcW-1:0]      cand;
    logic [NumSrc-1:0]    grant;
    logic [NumSrc-1:0]    drop;

    assign load = !out_vld_q || out_ready_i;

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NumSrc; k++) begin
            cand = SrcW'((int'(last_q) + k) % NumSrc);
            if (load && !gnt_any && slot_vld_q[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // A slot being drained this cycle can accept a new report at the same time.
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_code_d = slot_code_q;
        drop        = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (grant[i]) begin
                slot_vld_d[i] = 1'b0;
            end
            if (src_valid_i[i]) begin
                if (!slot_vld_q[i] || grant[i]) begin
                    slot_vld_d[i]  = 1'b1;
                    slot_addr_d[i] = src_addr_i[i*AddrWidth +: AddrWidth];
                    slot_code_d[i] = src_code_i[i*ErrBits +: ErrBits];
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_addr_d = out_addr_q;
        out_code_d = out_code_q;
        out_src_d  = out_src_q;
        last_d     = last_q;
        if (load) begin
            out_vld_d = gnt_any;
            if (gnt_any) begin
                out_addr_d = slot_addr_q[gnt_idx];
                out_code_d = slot_code_q[gnt_idx];
                out_src_d  = gnt_idx;
                last_d     = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_vld_q <= '0;
            for (int i = 0; i < NumSrc; i++) begin
                slot_addr_q[i] <= '0;
                slot_code_q[i] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_code_q <= '0;
            out_src_q  <= '0;
            last_q     <= SrcW'(NumSrc - 1);
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_code_q <= slot_code_d;
            out_vld_q   <= out_vld_d;
            out_addr_q  <= out_addr_d;
            out_code_q  <= out_code_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign out_valid_o = out_vld_q;
    assign out_addr_o  = out_addr_q;
    assign out_code_o  = out_code_q;
    assign out_src_o   = out_src_q;
    assign drop_o      = drop;

`ifdef BUS_ERR_ARB_DROP_CNT_EN
    localparam int SumW = CntWidth + 5;

    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic [SumW-1:0]     cnt_sum;

    // Extra headroom bits let overflow be detected before clamping.
    always_comb begin
        cnt_sum = SumW'(drop_cnt_q);
        for (int i = 0; i < NumSrc; i++) begin
            cnt_sum = cnt_sum + SumW'(drop[i]);
        end
        if (cnt_clr_i) begin
            drop_cnt_d = '0;
        end else if (|cnt_sum[SumW-1:CntWidth]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = cnt_sum[CntWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign drop_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_bus_err_arb.sv
// tb/tb_bus_err_arb.sv - self-checking bench for bus_err_arb with a record-level reference model
module tb_bus_err_arb;
    localparam int N  = 4;
    localparam int AW = 48;
    localparam int EB = 3;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*AW-1:0] src_addr;
    logic [N*EB-1:0] src_code;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_addr;
    logic [EB-1:0]   out_code;
    logic [1:0]      out_src;
    logic [N-1:0]    drop;
    logic            cnt_clr;
    logic [CW-1:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    bus_err_arb #(.NumSrc(N), .AddrWidth(AW), .ErrBits(EB), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .src_valid_i(src_valid), .src_addr_i(src_addr), .src_code_i(src_code),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_code_o(out_code), .out_src_o(out_src),
        .drop_o(drop), .cnt_clr_i(cnt_clr), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: one pending record per source, one output record.
    bit            m_live = 1'b0;
    bit            m_pend [N];
    logic [AW-1:0] m_pa   [N];
    logic [EB-1:0] m_pc   [N];
    bit            m_ov;
    logic [AW-1:0] m_oa;
    logic [EB-1:0] m_oc;
    int            m_os;
    int            m_last;
    int            m_cnt;

    always @(negedge clk) begin
        int       win;
        bit       take;
        bit [N-1:0] exp_drop;
        win  = -1;
        take = !m_ov || out_ready;
        if (take) begin
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && m_pend[(m_last + k) % N]) win = (m_last + k) % N;
            end
        end
        exp_drop = '0;
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && m_pend[i] && win != i) exp_drop[i] = 1'b1;
        end

        if (m_live) begin
            check("out_valid", 64'(out_valid), 64'(m_ov));
            check("out_addr", 64'(out_addr), 64'(m_oa));
            check("out_code", 64'(out_code), 64'(m_oc));
            check("out_src", 64'(out_src), 64'(m_os));
            check("drop", 64'(drop), 64'(exp_drop));
            check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
        end

        if (!rst_n) begin
            m_live = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0; m_pa[i] = '0; m_pc[i] = '0;
            end
            m_ov = 1'b0; m_oa = '0; m_oc = '0; m_os = 0; m_last = N - 1; m_cnt = 0;
        end else if (m_live) begin
`ifdef BUS_ERR_ARB_DROP_CNT_EN
            if (cnt_clr) m_cnt = 0;
            else m_cnt = (m_cnt + $countones(exp_drop) > 255) ? 255 : m_cnt + $countones(exp_drop);
`endif
            if (take) begin
                m_ov = (win >= 0);
                if (win >= 0) begin
                    m_oa = m_pa[win]; m_oc = m_pc[win]; m_os = win; m_last = win;
                    m_pend[win] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && !exp_drop[i]) begin
                    m_pend[i] = 1'b1;
                    m_pa[i] = src_addr[i*AW +: AW];
                    m_pc[i] = src_code[i*EB +: EB];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [EB-1:0] c);
        src_valid[i] = 1'b1;
        src_addr[i*AW +: AW] = a;
        src_code[i*EB +: EB] = c;
    endtask

    initial begin
        rst_n = 1'b0; src_valid = '0; src_addr = '0; src_code = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_cnt", 64'(drop_cnt), 64'd0);

        // Single source latency
        set_src(2, 48'h1000, 3'd3);
        cyc(); src_valid = '0;
        check("single_early", 64'(out_valid), 64'd0);
        cyc();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_src", 64'(out_src), 64'd2);
        check("single_addr", 64'(out_addr), 64'h1000);
        check("single_code", 64'(out_code), 64'd3);
        cyc();
        check("single_once", 64'(out_valid), 64'd0);

        // Round-robin order from a fresh search position (last winner was 2)
        for (int i = 0; i < N; i++) set_src(i, 48'h2000 + 48'(i), 3'(i));
        cyc(); src_valid = '0;
        cyc();
        for (int i = 0; i < N; i++) begin
            check("rr_src", 64'(out_src), 64'((3 + i) % N));
            check("rr_addr", 64'(out_addr), 64'h2000 + 64'((3 + i) % N));
            cyc();
        end
        check("rr_done", 64'(out_valid), 64'd0);

        // Backpressure and drop
        out_ready = 1'b0;
        set_src(1, 48'hA1, 3'd1);
        cyc(); src_valid = '0;
        cyc();
        check("bp_first", 64'(out_addr), 64'hA1);
        set_src(1, 48'hB2, 3'd2);
        cyc(); src_valid = '0;
        set_src(1, 48'hC3, 3'd4);
        #1;
        check("bp_drop", 64'(drop), 64'h2);
        cyc(); src_valid = '0;
`ifdef BUS_ERR_ARB_DROP_CNT_EN
        check("bp_cnt", 64'(drop_cnt), 64'd1);
`else
        check("bp_cnt", 64'(drop_cnt), 64'd0);
`endif
        check("bp_hold", 64'(out_addr), 64'hA1);
        out_ready = 1'b1;
        cyc();
        check("bp_second", 64'(out_addr), 64'hB2);
        check("bp_second_v", 64'(out_valid), 64'd1);
        cyc();
        check("bp_only2", 64'(out_valid), 64'd0);

        // Refill on grant
        set_src(0, 48'h55, 3'd5);
        cyc();
        set_src(0, 48'h66, 3'd6);
        #1;
        check("refill_nodrop", 64'(drop), 64'd0);
        cyc(); src_valid = '0;
        check("refill_a", 64'(out_addr), 64'h55);
        cyc();
        check("refill_b", 64'(out_addr), 64'h66);
        cyc();
        check("refill_end", 64'(out_valid), 64'd0);

        // Saturation and clear
        out_ready = 1'b0;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) set_src(i, 48'h3000 + 48'(c), 3'(i));
            cyc();
        end
`ifdef BUS_ERR_ARB_DROP_CNT_EN
        check("sat_cnt", 64'(drop_cnt), 64'd255);
`else
        check("sat_cnt", 64'(drop_cnt), 64'd0);
`endif
        cnt_clr = 1'b1;
        #1;
        check("clr_drop", 64'(drop), 64'hF);
        cyc();
        cnt_clr = 1'b0; src_valid = '0;
        check("clr_cnt", 64'(drop_cnt), 64'd0);

        // Reset mid-stream with full slots and a held record
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr", 64'(out_addr), 64'd0);
        check("mid_rst_code", 64'(out_code), 64'd0);
        check("mid_rst_src", 64'(out_src), 64'd0);
        check("mid_rst_cnt", 64'(drop_cnt), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            check("no_stale", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
